// File: rtl/poly_ram_port_arbiter.sv
// Two-requester arbiter for one port of a byte-enabled poly RAM, with tagged two-stage read return.
// Optional perf counters (grant_cnt0/1, stall_cnt) are built when POLY_ARB_PERF_CNT_EN is defined.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module poly_ram_port_arbiter #(
    parameter int LOCK_MAX = 16
`ifdef POLY_ARB_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             r0_valid,
    output logic                             r0_ready,
    input  logic [`LINE_SIZE-1:0]            r0_we,
    input  logic [`ADDR_WIDTH-1:0]           r0_addr,
    input  logic [`BIT_WIDTH*`LINE_SIZE-1:0] r0_din,
    input  logic                             r0_lock,
    output logic                             r0_rvalid,
    output logic [`BIT_WIDTH*`LINE_SIZE-1:0] r0_rdata,
    input  logic                             r1_valid,
    output logic                             r1_ready,
    input  logic [`LINE_SIZE-1:0]            r1_we,
    input  logic [`ADDR_WIDTH-1:0]           r1_addr,
    input  logic [`BIT_WIDTH*`LINE_SIZE-1:0] r1_din,
    input  logic                             r1_lock,
    output logic                             r1_rvalid,
    output logic [`BIT_WIDTH*`LINE_SIZE-1:0] r1_rdata,
    output logic [`LINE_SIZE-1:0]            ram_we,
    output logic [`ADDR_WIDTH-1:0]           ram_addr,
    output logic [`BIT_WIDTH*`LINE_SIZE-1:0] ram_din,
    output logic                             ram_en,
    input  logic [`BIT_WIDTH*`LINE_SIZE-1:0] ram_dout
`ifdef POLY_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                 grant_cnt0,
    output logic [CNT_W-1:0]                 grant_cnt1,
    output logic [CNT_W-1:0]                 stall_cnt
`endif
);

    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic {LAST_R0, LAST_R1} last_e;

    last_e          last_q, last_d;
    logic           owned_q;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           gnt0, gnt1, both, regrant;
    logic           acc0, acc1, rd_acc;
    logic           s1_vld, s1_id, s2_vld, s2_id;

    // owned_q keeps the reset-time pointer from being treated as a lock holder
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        regrant    = 1'b0;
        last_d     = last_q;
        lock_cnt_d = '0;
        both       = r0_valid & r1_valid;
        if (both) begin
            if (owned_q && (lock_cnt_q < LCW'(LOCK_MAX)) &&
                ((last_q == LAST_R0) ? r0_lock : r1_lock))
                regrant = 1'b1;
            if (regrant ? (last_q == LAST_R0) : (last_q == LAST_R1))
                gnt0 = 1'b1;
            else
                gnt1 = 1'b1;
        end else begin
            gnt0 = r0_valid;
            gnt1 = r1_valid;
        end
        if (regrant)
            lock_cnt_d = lock_cnt_q + LCW'(1);
        if (gnt0)
            last_d = LAST_R0;
        else if (gnt1)
            last_d = LAST_R1;
    end

    assign r0_ready = gnt0 & rstn;
    assign r1_ready = gnt1 & rstn;
    assign acc0     = r0_valid & r0_ready;
    assign acc1     = r1_valid & r1_ready;
    assign rd_acc   = acc0 ? ~|r0_we : (acc1 & ~|r1_we);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q     <= LAST_R1;
            owned_q    <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            if (acc0 | acc1)
                owned_q <= 1'b1;
        end
    end

    always_comb begin
        ram_we   = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (acc0) begin
            ram_we   = r0_we;
            ram_addr = r0_addr;
            ram_din  = r0_din;
        end else if (acc1) begin
            ram_we   = r1_we;
            ram_addr = r1_addr;
            ram_din  = r1_din;
        end
    end

    // Stage 1 enables the RAM output register, stage 2 presents its data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld <= 1'b0;
            s1_id  <= 1'b0;
            s2_vld <= 1'b0;
            s2_id  <= 1'b0;
        end else begin
            s1_vld <= rd_acc;
            s1_id  <= acc1;
            s2_vld <= s1_vld;
            s2_id  <= s1_id;
        end
    end

    assign ram_en    = s1_vld;
    assign r0_rvalid = s2_vld & ~s2_id;
    assign r1_rvalid = s2_vld & s2_id;
    assign r0_rdata  = ram_dout;
    assign r1_rdata  = ram_dout;

`ifdef POLY_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (acc0 && (grant_cnt0 != '1))
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (acc1 && (grant_cnt1 != '1))
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            if (both && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
